// File: rtl/alu_seq_pkg.sv
// Shared opcode map, FSM encoding and flag bundle for the sequential ALU.
// The opcode values match the original 8-bit combinational ALU.
package alu_seq_pkg;

   localparam logic [2:0] OP_NOT  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b011;
   localparam logic [2:0] OP_MUL  = 3'b100;
   localparam logic [2:0] OP_ADD  = 3'b101;
   localparam logic [2:0] OP_SUB  = 3'b110;
   localparam logic [2:0] OP_ZERO = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      MUL  = 2'b01,
      HOLD = 2'b10
   } state_e;

   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic v;
   } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per clock,
// WIDTH partial products in total, done pulses once the product is complete.
module alu_mul_iter
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand_r;
   logic [WIDTH-1:0]   mplier_r;
   logic [2*WIDTH-1:0] acc_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               busy_r;
   logic               done_r;
   logic [2*WIDTH-1:0] pp_s;

   // Select the current partial product from the multiplier LSB.
   always_comb begin
      pp_s = {(2*WIDTH){1'b0}};
      if (mplier_r[0]) begin
         pp_s = mcand_r;
      end else begin
         pp_s = {(2*WIDTH){1'b0}};
      end
   end

   // The start edge already folds in partial product 0, so WIDTH-1 more follow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_r  <= {(2*WIDTH){1'b0}};
         mplier_r <= {WIDTH{1'b0}};
         acc_r    <= {(2*WIDTH){1'b0}};
         cnt_r    <= {CNT_W{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (start) begin
            acc_r    <= b[0] ? {{WIDTH{1'b0}}, a} : {(2*WIDTH){1'b0}};
            mcand_r  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier_r <= {1'b0, b[WIDTH-1:1]};
            cnt_r    <= CNT_W'(WIDTH - 1);
            busy_r   <= 1'b1;
         end else if (busy_r) begin
            acc_r    <= acc_r + pp_s;
            mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            cnt_r    <= cnt_r - CNT_W'(1);
            if (cnt_r == CNT_W'(1)) begin
               busy_r <= 1'b0;
               done_r <= 1'b1;
            end
         end
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign product = acc_r;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides. Single-cycle ops load the
// result on the acceptance edge; MUL is sequenced through alu_mul_iter.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter bit MUL_OUT_FULL = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_hi,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             flag_v
);

   state_e             state_r;
   state_e             state_nxt_s;
   logic               accept_s;
   logic               mul_start_s;
   logic               mul_busy_s;
   logic               mul_done_s;
   logic [2*WIDTH-1:0] mul_product_s;

   logic [WIDTH-1:0]   b_op_s;
   logic [WIDTH:0]     sum_s;
   logic [WIDTH-1:0]   alu_res_s;
   flags_t             alu_flags_s;
   logic [WIDTH-1:0]   mul_hi_s;
   flags_t             mul_flags_s;

   logic               load_s;
   logic [WIDTH-1:0]   load_res_s;
   logic [WIDTH-1:0]   load_hi_s;
   flags_t             load_flags_s;
   logic               out_valid_nxt_s;
   logic               in_ready_nxt_s;

   logic [WIDTH-1:0]   out_r;
   logic [WIDTH-1:0]   out_hi_r;
   flags_t             flags_r;
   logic               out_valid_r;
   logic               in_ready_r;

   assign accept_s    = in_valid && in_ready_r && (state_r == IDLE) && !out_valid_r;
   assign mul_start_s = accept_s && (opcode == OP_MUL);

   alu_mul_iter #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start_s),
      .a       (a),
      .b       (b),
      .busy    (mul_busy_s),
      .done    (mul_done_s),
      .product (mul_product_s)
   );

   // Single-cycle datapath; SUB reuses the adder as a + ~b + 1.
   always_comb begin
      b_op_s      = (opcode == OP_SUB) ? ~b : b;
      sum_s       = {1'b0, a} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, (opcode == OP_SUB)};
      alu_res_s   = {WIDTH{1'b0}};
      alu_flags_s = flags_t'(4'b0000);
      case (opcode)
         OP_NOT: alu_res_s = ~a;
         OP_OR:  alu_res_s = a | b;
         OP_XOR: alu_res_s = a ^ b;
         OP_AND: alu_res_s = a & b;
         OP_ADD: begin
            alu_res_s     = sum_s[WIDTH-1:0];
            alu_flags_s.c = sum_s[WIDTH];
            alu_flags_s.v = (a[WIDTH-1] == b_op_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res_s     = sum_s[WIDTH-1:0];
            alu_flags_s.c = ~sum_s[WIDTH];
            alu_flags_s.v = (a[WIDTH-1] == b_op_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
         end
         default: alu_res_s = {WIDTH{1'b0}};
      endcase
      alu_flags_s.z = (alu_res_s == {WIDTH{1'b0}});
      alu_flags_s.n = alu_res_s[WIDTH-1];
   end

   // Product formatting; flag_c reflects the upper half even when out_hi is tied off.
   always_comb begin
      mul_flags_s.z = (mul_product_s[WIDTH-1:0] == {WIDTH{1'b0}});
      mul_flags_s.n = mul_product_s[WIDTH-1];
      mul_flags_s.c = |mul_product_s[2*WIDTH-1:WIDTH];
      mul_flags_s.v = 1'b0;
      if (MUL_OUT_FULL) begin
         mul_hi_s = mul_product_s[2*WIDTH-1:WIDTH];
      end else begin
         mul_hi_s = {WIDTH{1'b0}};
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; a lost multiplier or stray state recovers to IDLE.
   always_comb begin
      state_nxt_s = IDLE;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nxt_s = (opcode == OP_MUL) ? MUL : HOLD;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         MUL: begin
            if (mul_done_s) begin
               state_nxt_s = HOLD;
            end else if (mul_busy_s) begin
               state_nxt_s = MUL;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         HOLD: begin
            if (!out_valid_r || out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = HOLD;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM output logic: result load strobe and next handshake flags.
   always_comb begin
      load_s          = 1'b0;
      load_res_s      = alu_res_s;
      load_hi_s       = {WIDTH{1'b0}};
      load_flags_s    = alu_flags_s;
      out_valid_nxt_s = out_valid_r;
      case (state_r)
         IDLE: begin
            if (accept_s && (opcode != OP_MUL)) begin
               load_s          = 1'b1;
               out_valid_nxt_s = 1'b1;
            end else begin
               load_s = 1'b0;
            end
         end
         MUL: begin
            if (mul_done_s) begin
               load_s          = 1'b1;
               load_res_s      = mul_product_s[WIDTH-1:0];
               load_hi_s       = mul_hi_s;
               load_flags_s    = mul_flags_s;
               out_valid_nxt_s = 1'b1;
            end else begin
               load_s = 1'b0;
            end
         end
         HOLD: begin
            if (out_valid_r && out_ready) begin
               out_valid_nxt_s = 1'b0;
            end else begin
               out_valid_nxt_s = out_valid_r;
            end
         end
         default: out_valid_nxt_s = 1'b0;
      endcase
      in_ready_nxt_s = (state_nxt_s == IDLE) && !out_valid_nxt_s;
   end

   // Result and handshake registers; results persist until the next load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_r       <= {WIDTH{1'b0}};
         out_hi_r    <= {WIDTH{1'b0}};
         flags_r     <= flags_t'(4'b0000);
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b0;
      end else begin
         if (load_s) begin
            out_r    <= load_res_s;
            out_hi_r <= load_hi_s;
            flags_r  <= load_flags_s;
         end
         out_valid_r <= out_valid_nxt_s;
         in_ready_r  <= in_ready_nxt_s;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out       = out_r;
   assign out_hi    = out_hi_r;
   assign flag_z    = flags_r.z;
   assign flag_n    = flags_r.n;
   assign flag_c    = flags_r.c;
   assign flag_v    = flags_r.v;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8, plus a short random sweep
// checked against an independent reference model.
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic [2:0] opcode;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out;
   logic [7:0] out_hi;
   logic       flag_z;
   logic       flag_n;
   logic       flag_c;
   logic       flag_v;

   int n_checks = 0;
   int n_fails  = 0;

   alu_seq #(
      .WIDTH        (8),
      .MUL_OUT_FULL (1'b1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .opcode    (opcode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .out_hi    (out_hi),
      .flag_z    (flag_z),
      .flag_n    (flag_n),
      .flag_c    (flag_c),
      .flag_v    (flag_v)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Result word plus flags {z,n,c,v}, checked together.
   task automatic check_res(input string tag, input logic [7:0] e_out, input logic [7:0] e_hi,
                            input logic [3:0] e_flags);
      check({tag, ".out"}, {24'd0, out}, {24'd0, e_out});
      check({tag, ".hi"}, {24'd0, out_hi}, {24'd0, e_hi});
      check({tag, ".zncv"}, {28'd0, flag_z, flag_n, flag_c, flag_v}, {28'd0, e_flags});
   endtask

   task automatic send(input logic [7:0] aa, input logic [7:0] bb, input logic [2:0] op);
      int k;
      k = 0;
      while (!in_ready && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      check("send_ready", {31'd0, in_ready}, 32'd1);
      a = aa; b = bb; opcode = op; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // lat=1 means out_valid is already high just after the acceptance edge.
   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   function automatic logic [19:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic [2:0] op);
      logic [7:0]  r;
      logic [7:0]  h;
      logic        c;
      logic        v;
      logic [8:0]  s;
      logic [15:0] p;
      r = 8'd0; h = 8'd0; c = 1'b0; v = 1'b0;
      case (op)
         3'b000: r = ~ma;
         3'b001: r = ma | mb;
         3'b010: r = ma ^ mb;
         3'b011: r = ma & mb;
         3'b100: begin p = ma * mb; r = p[7:0]; h = p[15:8]; c = (h != 8'd0); end
         3'b101: begin s = ma + mb; r = s[7:0]; c = s[8]; v = (ma[7] == mb[7]) && (r[7] != ma[7]); end
         3'b110: begin r = ma - mb; c = (ma < mb); v = (ma[7] != mb[7]) && (r[7] != ma[7]); end
         default: r = 8'd0;
      endcase
      return {r, h, (r == 8'd0), r[7], c, v};
   endfunction

   initial begin
      int lat;
      int cnt;
      logic [7:0]  ra;
      logic [7:0]  rb;
      logic [2:0]  rop;
      logic [19:0] m;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = 8'd0; b = 8'd0; opcode = 3'b000;
      #22;
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rel_in_ready", {31'd0, in_ready}, 32'd1);

      // ADD overflow / carry
      send(8'h7F, 8'h01, 3'b101); wait_out(lat);
      check("add1_lat", lat, 32'd1);
      check_res("add1", 8'h80, 8'h00, 4'b0101); take();
      send(8'hFF, 8'h01, 3'b101); wait_out(lat);
      check_res("add2", 8'h00, 8'h00, 4'b1010); take();

      // SUB borrow / overflow
      send(8'h05, 8'h07, 3'b110); wait_out(lat);
      check_res("sub1", 8'hFE, 8'h00, 4'b0110); take();
      send(8'h80, 8'h01, 3'b110); wait_out(lat);
      check_res("sub2", 8'h7F, 8'h00, 4'b0001); take();

      // MUL
      send(8'd200, 8'd3, 3'b100); wait_out(lat);
      check("mul1_lat", lat, 32'd9);
      check_res("mul1", 8'h58, 8'h02, 4'b0010); take();
      send(8'd15, 8'd17, 3'b100); wait_out(lat);
      check("mul2_lat", lat, 32'd9);
      check_res("mul2", 8'hFF, 8'h00, 4'b0100); take();

      // Asynchronous reset mid-multiply; the previous result (0xFF) must clear
      send(8'd200, 8'd3, 3'b100);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mrst_in_ready", {31'd0, in_ready}, 32'd0);
      check_res("mrst", 8'h00, 8'h00, 4'b0000);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("mrst_rel_ready", {31'd0, in_ready}, 32'd1);
      cnt = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid) cnt++;
      end
      check("mrst_no_stale", cnt, 32'd0);

      // Backpressure on an XOR result
      send(8'hF0, 8'h3C, 3'b010); wait_out(lat);
      a = 8'h01; b = 8'h02; opcode = 3'b001; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_valid", {31'd0, out_valid}, 32'd1);
         check("bp_ready", {31'd0, in_ready}, 32'd0);
         check_res("bp", 8'hCC, 8'h00, 4'b0100);
      end
      in_valid = 1'b0;
      take();
      check("bp_after_valid", {31'd0, out_valid}, 32'd0);
      check("bp_after_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      check("bp_no_accept", {31'd0, out_valid}, 32'd0);

      // Logic / ZERO sweep
      send(8'h0F, 8'h00, 3'b000); wait_out(lat);
      check_res("not", 8'hF0, 8'h00, 4'b0100); take();
      send(8'h0F, 8'hF0, 3'b001); wait_out(lat);
      check_res("or", 8'hFF, 8'h00, 4'b0100); take();
      send(8'h0F, 8'hF0, 3'b011); wait_out(lat);
      check_res("and", 8'h00, 8'h00, 4'b1000); take();
      send(8'hA5, 8'h5A, 3'b111); wait_out(lat);
      check_res("zero", 8'h00, 8'h00, 4'b1000); take();

      // Throughput: streaming with out_ready high gives one result per 2 cycles
      a = 8'h12; b = 8'h34; opcode = 3'b010; in_valid = 1'b1; out_ready = 1'b1;
      cnt = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (out_valid) cnt++;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("thruput", cnt, 32'd5);

      // Random back-to-back ops across all opcodes
      for (int i = 0; i < 24; i++) begin
         ra = 8'($urandom_range(255, 0));
         rb = 8'($urandom_range(255, 0));
         rop = (i < 8) ? 3'(i) : 3'($urandom_range(7, 0));
         m = model(ra, rb, rop);
         send(ra, rb, rop); wait_out(lat);
         check("rnd_valid", {31'd0, out_valid}, 32'd1);
         check_res("rnd", m[19:12], m[11:4], m[3:0]);
         take();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor of the team's 8-bit combinational ALU; the opcode map is unchanged.
- Adds valid/ready handshakes on both sides, a registered result with status flags, and a full-width multiply computed iteratively (shift-add) instead of in one combinational cycle.
- Sits between an operand/instruction source and a result consumer, both of which may stall.

Parameters:
WIDTH, 8, operand and result width in bits (>=2)
MUL_OUT_FULL, 1, 1 = out_hi carries the upper WIDTH bits of the product; 0 = out_hi is tied to 0

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands and opcode are valid
in_ready  out  1  block can accept a new operation
a  in  WIDTH  operand A
b  in  WIDTH  operand B
opcode  in  3  000 NOT A, 001 OR, 010 XOR, 011 AND, 100 MUL, 101 ADD, 110 SUB (A-B), 111 ZERO
out_valid  out  1  result registers are valid
out_ready  in  1  consumer accepts the result
out  out  WIDTH  result (low WIDTH bits for MUL)
out_hi  out  WIDTH  upper product bits for MUL, 0 for all other opcodes
flag_z  out  1  out == 0
flag_n  out  1  out[WIDTH-1]
flag_c  out  1  ADD carry-out; SUB borrow (a<b unsigned); MUL |upper product; 0 otherwise
flag_v  out  1  signed overflow for ADD/SUB; 0 otherwise

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n). Reset drives state=IDLE, in_ready=0 while rst_n is low, and clears out_valid, out, out_hi and all flags to 0. Reset mid-multiply abandons the operation and produces no output.
- FSM states: IDLE, MUL, HOLD.
- in_ready = (state==IDLE) && !out_valid. The block accepts no new operation while a result is pending.
- Acceptance occurs on a rising edge with in_valid && in_ready. The block captures a, b and opcode on that edge.
- Non-MUL ops: IDLE->HOLD. out/flags are registered on the acceptance edge, so out_valid is high in the next cycle. Latency is 1 cycle.
- MUL: IDLE->MUL. The shift-add multiplier runs exactly WIDTH cycles (one partial product per cycle, unsigned). On the WIDTH-th edge after acceptance, out, out_hi and flags are loaded, out_valid is set and the FSM enters HOLD. Latency is WIDTH+1 cycles to out_valid. Operands are unsigned; flag_n and flag_z use the low WIDTH bits only; flag_v=0.
- HOLD: out, out_hi, flags and out_valid stay stable until out_valid && out_ready. On that edge out_valid clears and the FSM returns to IDLE. The next acceptance can occur one cycle later; there is no same-cycle pass-through.
- Arithmetic: ADD/SUB use a WIDTH+1-bit internal sum and truncate to WIDTH. flag_v = (a_msb==b'_msb) && (res_msb!=a_msb), where b' is b for ADD and ~b for SUB.
- ZERO: out=0, flag_z=1, other flags 0.
- Unknown states fall back to IDLE.
- in_valid may drop without acceptance; the block ignores it.
- out_ready held high continuously gives one result per 2 cycles (non-MUL).

Decomposition:
- Package alu_seq_pkg: opcode localparams (OP_NOT..OP_ZERO) and the FSM state encoding (IDLE, MUL, HOLD).
- Sub-module alu_mul_iter, an iterative unsigned shift-add multiplier parametrised by WIDTH.
  - Ports: start, a, b → busy, done (1-cycle pulse), product[2*WIDTH-1:0].
  - Instantiated once; the top FSM sequences it.

Test Plan (WIDTH=8):
1. Reset: assert rst_n=0 mid-MUL (a=200, b=3) → out_valid=0, out=0, flags=0 asynchronously. After release, in_ready=1 next cycle and no stale result appears.
2. ADD overflow: a=0x7F, b=0x01, op=101 → out=0x80 one cycle after accept, flag_n=1, flag_v=1, flag_c=0, flag_z=0. ADD a=0xFF, b=0x01 → out=0x00, flag_z=1, flag_c=1, flag_v=0.
3. SUB borrow: a=0x05, b=0x07, op=110 → out=0xFE, flag_c=1, flag_n=1, flag_v=0. a=0x80, b=0x01 → out=0x7F, flag_v=1.
4. MUL: a=200, b=3, op=100 → out_valid exactly 9 cycles after accept, out=0x58, out_hi=0x02, flag_c=1. a=15, b=17 → out=0xFF, out_hi=0, flag_c=0.
5. Backpressure: out_ready=0 for 5 cycles after an XOR result (a=0xF0, b=0x3C → 0xCC). Output stays stable, in_ready=0, and a new in_valid is not accepted. Raise out_ready → accept the result, then in_ready=1 the following cycle.
6. Logic/ZERO sweep: NOT 0x0F → 0xF0; OR 0x0F|0xF0 → 0xFF; AND 0x0F&0xF0 → 0x00 with flag_z=1; op=111 → 0x00, flag_z=1. Randomised back-to-back ops compared against a reference model for all 8 opcodes.
